keypad_key_ctrl: RTL and testbench
==================================

Name: keypad_key_ctrl

Overview:
Controller that sequences the keypad scanner. It watches the scanner's row index, synchronized columns and key-detect flag, and freezes row scanning (scan_hold) once a press is seen. It debounces press and release, then emits a one-cycle key event with a hex key code. It keeps a two-digit history (newest/older) for the seven-segment display path.

Parameters:
DEBOUNCE_CYCLES, 150000, consecutive stable samples required for press/release acceptance (50 ms at 3 MHz); minimum 2.
CW, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (derived, not overridden).

Ports:
clk  input  1  system clock (3 MHz)
rst  input  1  synchronous active-high reset
row_idx  input  4  one-hot active row from scanner
col_sync  input  4  synchronized columns, active-low
key_detected  input  1  scanner flag: any col_sync bit low
scan_hold  output  1  1 = scanner must stop advancing rows
key_valid  output  1  one-cycle pulse: debounced new key accepted
key_code  output  4  hex code of last accepted key
digit_new  output  4  most recent accepted key
digit_old  output  4  key accepted before digit_new

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; counter=0; scan_hold=0, key_valid=0, key_code=0, digit_new=0, digit_old=0; captured row/col=0. Reset wins over every other event, in any state.
- All outputs registered. All inputs sampled on rising clk.
- Valid sample: key_detected=1, row_idx one-hot, col_sync exactly one bit low. Anything else counts as "no valid key".
- Key map, row index r (bit position of row_idx) by column c (bit position of low col_sync bit):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- IDLE: scan_hold=0. On a valid sample: capture row_idx and col_sync, set counter=1, go to DEBOUNCE. scan_hold=1 from the next cycle.
- DEBOUNCE: scan_hold=1.
  - row_idx and col_sync equal the captured values: counter++.
  - On the sample where counter would reach DEBOUNCE_CYCLES: go to HELD, set counter=0, key_valid=1 for the next cycle only, key_code=mapped code, digit_old<=digit_new, digit_new<=code.
  - Any mismatch: go to IDLE, counter=0, scan_hold=0 next cycle, no key_valid.
- Latency: first valid sample at edge E0 puts key_valid high in the cycle after edge E(DEBOUNCE_CYCLES-1).
- HELD: scan_hold=1. Stay while the captured column bit is low. Other columns going low are ignored (no rollover events). When the captured column bit goes high, go to RELEASE with counter=1.
- RELEASE: scan_hold=1.
  - Captured column bit high: counter++. On reaching DEBOUNCE_CYCLES, go to IDLE, counter=0, scan_hold=0 next cycle.
  - Captured column bit low again: go to HELD, counter=0, no new key_valid.
- key_valid never asserts twice for one physical press. It is never high in two consecutive cycles.
- key_code, digit_new and digit_old hold their values until the next accepted key or reset.
- Counter saturates; no wrap-around is possible because each state exits at DEBOUNCE_CYCLES.
- Unused state encodings go to IDLE.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4.
1. Reset: rst=1 for 2 cycles with col_sync=1110 applied -> scan_hold=0, key_valid=0, key_code=0, digit_new=0, digit_old=0 after release of reset; no event for 3 cycles after rst falls until debounce completes.
2. Clean press: row_idx=0001, col_sync=1101, key_detected=1 held for 10 cycles -> scan_hold=1 from cycle 2; key_valid=1 exactly one cycle, in the cycle after the 4th sample; key_code=2, digit_new=2, digit_old=0.
3. Press bounce: col_sync=1110 for 2 cycles, then 1111 -> no key_valid; scan_hold returns to 0; digits unchanged.
4. Second key: after a full release, row_idx=0100, col_sync=1110 for 6 cycles -> key_valid once, key_code=7, digit_new=7, digit_old=2.
5. Release glitch: in RELEASE, col_sync high 2 cycles, low 1 cycle, high 4 cycles -> no second key_valid; scan_hold drops only after the 4 consecutive high samples.
6. Invalid input and mid-operation reset:
   - col_sync=1100 in IDLE -> stays IDLE, scan_hold=0.
   - row_idx=0011 with a single column low -> ignored.
   - rst=1 during DEBOUNCE (counter=2) -> all outputs 0 the next cycle; the subsequent press is fully re-debounced.

Source files
------------

// File: rtl/keypad_key_ctrl.sv
// Keypad key controller: freezes row scanning on a press, debounces press and
// release, emits a one-cycle key event with hex code and a two-digit history.
module keypad_key_ctrl #(
   parameter  int DEBOUNCE_CYCLES = 150000,  // must be >= 2
   localparam int CW              = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_idx,
   input  logic [3:0] col_sync,
   input  logic       key_detected,
   output logic       scan_hold,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic [3:0] digit_new,
   output logic [3:0] digit_old
);

   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [CW-1:0] CNT_ZERO = '0;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_DEBOUNCE = 2'd1,
      S_HELD     = 2'd2,
      S_RELEASE  = 2'd3
   } state_t;

   function automatic logic is_one_hot(input logic [3:0] v);
      return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
   endfunction

   function automatic logic [1:0] one_hot_idx(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      case (v)
         4'b0001: idx = 2'd0;
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   // Row r, column c -> printed legend of the 4x4 pad
   function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      code = 4'h0;
      case ({r, c})
         4'b00_00: code = 4'h1;
         4'b00_01: code = 4'h2;
         4'b00_10: code = 4'h3;
         4'b00_11: code = 4'hA;
         4'b01_00: code = 4'h4;
         4'b01_01: code = 4'h5;
         4'b01_10: code = 4'h6;
         4'b01_11: code = 4'hB;
         4'b10_00: code = 4'h7;
         4'b10_01: code = 4'h8;
         4'b10_10: code = 4'h9;
         4'b10_11: code = 4'hC;
         4'b11_00: code = 4'hE;
         4'b11_01: code = 4'h0;
         4'b11_10: code = 4'hF;
         4'b11_11: code = 4'hD;
         default:  code = 4'h0;
      endcase
      return code;
   endfunction

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n, cnt_inc;
   logic [3:0]    cap_row, cap_row_n;
   logic [3:0]    cap_col, cap_col_n;
   logic          hold_n, valid_n;
   logic [3:0]    code_n, new_n, old_n;

   logic          valid_sample;
   logic          same_key;
   logic [1:0]    cap_r, cap_c;
   logic          cap_col_high;

   assign valid_sample = key_detected && is_one_hot(row_idx) && is_one_hot(~col_sync);
   assign same_key     = (row_idx == cap_row) && (col_sync == cap_col);
   assign cap_r        = one_hot_idx(cap_row);
   assign cap_c        = one_hot_idx(~cap_col);
   // Only the captured column matters once held; other columns are ignored
   assign cap_col_high = col_sync[cap_c];
   assign cnt_inc      = cnt + CNT_ONE;

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      cap_row_n = cap_row;
      cap_col_n = cap_col;
      valid_n   = 1'b0;
      code_n    = key_code;
      new_n     = digit_new;
      old_n     = digit_old;

      case (state)
         S_IDLE: begin
            if (valid_sample) begin
               cap_row_n = row_idx;
               cap_col_n = col_sync;
               cnt_n     = CNT_ONE;
               state_n   = S_DEBOUNCE;
            end
         end

         S_DEBOUNCE: begin
            if (!same_key) begin
               cnt_n   = CNT_ZERO;
               state_n = S_IDLE;
            end else if (cnt_inc == DB_LAST) begin
               cnt_n   = CNT_ZERO;
               state_n = S_HELD;
               valid_n = 1'b1;
               code_n  = key_map(cap_r, cap_c);
               old_n   = digit_new;
               new_n   = key_map(cap_r, cap_c);
            end else begin
               cnt_n = cnt_inc;
            end
         end

         S_HELD: begin
            if (cap_col_high) begin
               cnt_n   = CNT_ONE;
               state_n = S_RELEASE;
            end
         end

         S_RELEASE: begin
            if (!cap_col_high) begin
               cnt_n   = CNT_ZERO;
               state_n = S_HELD;
            end else if (cnt_inc == DB_LAST) begin
               cnt_n   = CNT_ZERO;
               state_n = S_IDLE;
            end else begin
               cnt_n = cnt_inc;
            end
         end

         default: begin
            cnt_n   = CNT_ZERO;
            state_n = S_IDLE;
         end
      endcase

      hold_n = (state_n != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= CNT_ZERO;
         cap_row   <= 4'd0;
         cap_col   <= 4'd0;
         scan_hold <= 1'b0;
         key_valid <= 1'b0;
         key_code  <= 4'd0;
         digit_new <= 4'd0;
         digit_old <= 4'd0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         cap_row   <= cap_row_n;
         cap_col   <= cap_col_n;
         scan_hold <= hold_n;
         key_valid <= valid_n;
         key_code  <= code_n;
         digit_new <= new_n;
         digit_old <= old_n;
      end
   end

endmodule

// File: tb/tb_keypad_key_ctrl.sv
// Directed bench for keypad_key_ctrl with DEBOUNCE_CYCLES=4.
module tb_keypad_key_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] row_idx;
   logic [3:0] col_sync;
   logic       key_detected;
   logic       scan_hold;
   logic       key_valid;
   logic [3:0] key_code;
   logic [3:0] digit_new;
   logic [3:0] digit_old;

   int tests = 0;
   int fails = 0;

   keypad_key_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .row_idx      (row_idx),
      .col_sync     (col_sync),
      .key_detected (key_detected),
      .scan_hold    (scan_hold),
      .key_valid    (key_valid),
      .key_code     (key_code),
      .digit_new    (digit_new),
      .digit_old    (digit_old)
   );

   always #5 clk = ~clk;

   // Advance one edge; outputs are sampled 1 time unit after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] r, input logic [3:0] c, input logic k);
      row_idx      = r;
      col_sync     = c;
      key_detected = k;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic h, input logic v,
                          input logic [3:0] code, input logic [3:0] dn, input logic [3:0] dold);
      chk({tag, ".hold"},  {3'b0, scan_hold}, {3'b0, h});
      chk({tag, ".valid"}, {3'b0, key_valid}, {3'b0, v});
      chk({tag, ".code"},  key_code,  code);
      chk({tag, ".new"},   digit_new, dn);
      chk({tag, ".old"},   digit_old, dold);
   endtask

   initial begin
      // 1. reset with a key already down
      rst = 1'b1;
      drive(4'b0001, 4'b1110, 1'b1);
      tick(); tick();
      chk_out("rst", 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
      rst = 1'b0;
      tick(); chk_out("rst_e0", 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
      tick(); chk_out("rst_e1", 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
      tick(); chk_out("rst_e2", 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
      drive(4'b0001, 4'b1111, 1'b0);
      tick(); chk_out("rst_abort", 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);

      // 2. clean press of '2'
      drive(4'b0001, 4'b1101, 1'b1);
      tick(); chk_out("p2_e0", 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
      tick(); chk_out("p2_e1", 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
      tick(); chk_out("p2_e2", 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
      tick(); chk_out("p2_e3", 1'b1, 1'b1, 4'h2, 4'h2, 4'h0);
      for (int i = 0; i < 6; i++) begin
         tick(); chk_out("p2_held", 1'b1, 1'b0, 4'h2, 4'h2, 4'h0);
      end
      drive(4'b0001, 4'b1111, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick(); chk_out("p2_rel", 1'b1, 1'b0, 4'h2, 4'h2, 4'h0);
      end
      tick(); chk_out("p2_idle", 1'b0, 1'b0, 4'h2, 4'h2, 4'h0);

      // 3. press bounce
      drive(4'b0001, 4'b1110, 1'b1);
      tick(); chk_out("bn_e0", 1'b1, 1'b0, 4'h2, 4'h2, 4'h0);
      tick(); chk_out("bn_e1", 1'b1, 1'b0, 4'h2, 4'h2, 4'h0);
      drive(4'b0001, 4'b1111, 1'b0);
      tick(); chk_out("bn_drop", 1'b0, 1'b0, 4'h2, 4'h2, 4'h0);
      tick(); chk_out("bn_idle", 1'b0, 1'b0, 4'h2, 4'h2, 4'h0);

      // 4. second key '7'
      drive(4'b0100, 4'b1110, 1'b1);
      tick(); chk_out("p7_e0", 1'b1, 1'b0, 4'h2, 4'h2, 4'h0);
      tick(); chk_out("p7_e1", 1'b1, 1'b0, 4'h2, 4'h2, 4'h0);
      tick(); chk_out("p7_e2", 1'b1, 1'b0, 4'h2, 4'h2, 4'h0);
      tick(); chk_out("p7_e3", 1'b1, 1'b1, 4'h7, 4'h7, 4'h2);
      tick(); chk_out("p7_e4", 1'b1, 1'b0, 4'h7, 4'h7, 4'h2);
      tick(); chk_out("p7_e5", 1'b1, 1'b0, 4'h7, 4'h7, 4'h2);

      // 5. release glitch: 2 high, 1 low, 4 high
      drive(4'b0100, 4'b1111, 1'b0);
      tick(); chk_out("rg_h1", 1'b1, 1'b0, 4'h7, 4'h7, 4'h2);
      tick(); chk_out("rg_h2", 1'b1, 1'b0, 4'h7, 4'h7, 4'h2);
      drive(4'b0100, 4'b1110, 1'b1);
      tick(); chk_out("rg_low", 1'b1, 1'b0, 4'h7, 4'h7, 4'h2);
      drive(4'b0100, 4'b1111, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick(); chk_out("rg_rel", 1'b1, 1'b0, 4'h7, 4'h7, 4'h2);
      end
      tick(); chk_out("rg_idle", 1'b0, 1'b0, 4'h7, 4'h7, 4'h2);

      // 6a. two columns low is not a valid sample
      drive(4'b0001, 4'b1100, 1'b1);
      tick(); chk_out("inv_col0", 1'b0, 1'b0, 4'h7, 4'h7, 4'h2);
      tick(); chk_out("inv_col1", 1'b0, 1'b0, 4'h7, 4'h7, 4'h2);
      // 6b. two rows active is not a valid sample
      drive(4'b0011, 4'b1110, 1'b1);
      tick(); chk_out("inv_row0", 1'b0, 1'b0, 4'h7, 4'h7, 4'h2);
      tick(); chk_out("inv_row1", 1'b0, 1'b0, 4'h7, 4'h7, 4'h2);

      // 6c. reset in DEBOUNCE, then full re-debounce of 'F'
      drive(4'b1000, 4'b1011, 1'b1);
      tick(); chk_out("mr_e0", 1'b1, 1'b0, 4'h7, 4'h7, 4'h2);
      tick(); chk_out("mr_e1", 1'b1, 1'b0, 4'h7, 4'h7, 4'h2);
      rst = 1'b1;
      tick(); chk_out("mr_rst", 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
      rst = 1'b0;
      tick(); chk_out("pf_e0", 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
      tick(); chk_out("pf_e1", 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
      tick(); chk_out("pf_e2", 1'b1, 1'b0, 4'h0, 4'h0, 4'h0);
      tick(); chk_out("pf_e3", 1'b1, 1'b1, 4'hF, 4'hF, 4'h0);
      tick(); chk_out("pf_e4", 1'b1, 1'b0, 4'hF, 4'hF, 4'h0);

      // Release, then 'B' (row 1, column 3) shifts history
      drive(4'b1000, 4'b1111, 1'b0);
      tick(); tick(); tick(); tick();
      chk_out("pf_idle", 1'b0, 1'b0, 4'hF, 4'hF, 4'h0);
      drive(4'b0010, 4'b0111, 1'b1);
      tick(); tick(); tick();
      chk_out("pb_e2", 1'b1, 1'b0, 4'hF, 4'hF, 4'h0);
      tick(); chk_out("pb_e3", 1'b1, 1'b1, 4'hB, 4'hB, 4'hF);
      tick(); chk_out("pb_e4", 1'b1, 1'b0, 4'hB, 4'hB, 4'hF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
